// File: rtl/ahb_lite_single_master_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_single_master_if
// Groups every signal of the single-master AHB-Lite initiator except clock
// and reset.
//   Command side  : cmd_valid, cmd_ready, cmd_write, cmd_size, cmd_addr,
//                   cmd_wdata
//   Response side : rsp_valid, rsp_err, rsp_rdata
//   AHB-Lite side : HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
//                   HWDATA (driven by the initiator), HRDATA, HREADY, HRESP
//                   (driven by the bus)
// Modports:
//   master - the initiator's view (ahb_lite_single_master)
//   slave  - the environment's view (engine plus bus/slave model)
// ---------------------------------------------------------------------------
interface ahb_lite_single_master_if #(
  parameter int ADDR_WIDTH = 32
);
  // command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [1:0]            cmd_size;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;

  // response side
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;

  // AHB-Lite side
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready,
    output rsp_valid, rsp_err, rsp_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready,
    input  rsp_valid, rsp_err, rsp_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/ahb_lite_single_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_single_master
// AHB-Lite initiator turning a valid/ready command stream into single
// (HBURST=SINGLE) transfers. The address and data phases are pipelined, so
// back-to-back commands reach the bus without idle cycles. Slave wait states
// and the two-cycle ERROR response are handled. Every accepted command gets
// exactly one rsp_valid pulse, in order.
//
// Ports:
//   HCLK    - clock
//   HRESET  - synchronous active-high reset
//   bus     - ahb_lite_single_master_if.master (command, response and
//             AHB-Lite signals)
// Parameters:
//   ADDR_WIDTH - width of HADDR / cmd_addr (must match the interface)
//   HPROT_VAL  - constant HPROT value
// Optional build macro:
//   AHB_MST_ERR_CANCEL_EN - when defined, a pipelined address phase is
//   cancelled (HTRANS=IDLE) during an ERROR response and reissued afterwards.
//   When undefined the address phase simply continues through the error.
// ---------------------------------------------------------------------------
module ahb_lite_single_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  ahb_lite_single_master_if.master   bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // address-phase register
  logic                  aph_valid;
  logic                  aph_illegal;
  logic                  aph_write;
  logic [1:0]            aph_size;
  logic [ADDR_WIDTH-1:0] aph_addr;
  logic [31:0]           aph_wdata;

  // data-phase register
  logic                  dph_valid;
  logic                  dph_illegal;
  logic                  dph_write;
  logic [31:0]           dph_wdata;

  // response register
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [31:0]           rsp_rdata_q;

  logic                  cmd_illegal;
  logic                  cmd_ready_int;
  logic                  accept;
  logic                  advance;
  logic                  hold;

  // Size 3 and misaligned half/word accesses never reach the bus; they ride
  // the pipeline as an IDLE slot and come back as an error response, which
  // keeps them ordered behind earlier transfers for free.
  always_comb begin
    cmd_illegal = 1'b0;
    case (bus.cmd_size)
      2'd1:    cmd_illegal = bus.cmd_addr[0];
      2'd2:    cmd_illegal = (bus.cmd_addr[1:0] != 2'b00);
      2'd3:    cmd_illegal = 1'b1;
      default: cmd_illegal = 1'b0;
    endcase
  end

`ifdef AHB_MST_ERR_CANCEL_EN
  logic hold_q;
  logic err_first;

  // The first ERROR cycle is combinationally visible, so the pending address
  // phase is withdrawn in that same cycle; hold_q keeps it withdrawn through
  // the second ERROR cycle, when the bus would otherwise sample it.
  assign err_first = dph_valid & ~dph_illegal & bus.HRESP & ~bus.HREADY;
  assign hold      = hold_q | (err_first & aph_valid);

  // hold_q is set on leaving the first ERROR cycle and cleared once the
  // erroring data phase completes, so the command reissues the next cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hold_q <= 1'b0;
    end else if (dph_valid & bus.HREADY) begin
      hold_q <= 1'b0;
    end else if (err_first & aph_valid) begin
      hold_q <= 1'b1;
    end
  end
`else
  assign hold = 1'b0;
`endif

  // A new command may enter aph when it is empty, or when it is leaving this
  // cycle because the bus is ready and nothing is held.
  assign cmd_ready_int = ~HRESET & ~hold & (~aph_valid | bus.HREADY);
  assign accept        = bus.cmd_valid & cmd_ready_int;
  assign advance       = bus.HREADY & ~hold;

  // Address-phase register. An illegal command only marks the slot; the bus
  // fields keep their last values so HADDR/HWRITE/HSIZE do not change.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_valid   <= 1'b0;
      aph_illegal <= 1'b0;
      aph_write   <= 1'b0;
      aph_size    <= 2'b00;
      aph_addr    <= '0;
      aph_wdata   <= '0;
    end else if (accept) begin
      aph_valid   <= 1'b1;
      aph_illegal <= cmd_illegal;
      if (!cmd_illegal) begin
        aph_write <= bus.cmd_write;
        aph_size  <= bus.cmd_size;
        aph_addr  <= bus.cmd_addr;
        aph_wdata <= bus.cmd_wdata;
      end
    end else if (advance) begin
      aph_valid <= 1'b0;
    end
  end

  // Data-phase register. Every HREADY edge ends the current data phase; the
  // address phase moves in unless it is being held back after an error.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_valid   <= 1'b0;
      dph_illegal <= 1'b0;
      dph_write   <= 1'b0;
      dph_wdata   <= '0;
    end else if (bus.HREADY) begin
      dph_valid <= aph_valid & ~hold;
      if (advance) begin
        dph_illegal <= aph_illegal;
        dph_write   <= aph_write;
        dph_wdata   <= aph_wdata;
      end
    end
  end

  // Response register: one pulse the cycle after a data phase completes.
  // Read data is only passed through for successful reads.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (dph_valid & bus.HREADY) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= dph_illegal | bus.HRESP;
      rsp_rdata_q <= (~dph_write & ~dph_illegal & ~bus.HRESP) ? bus.HRDATA : 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end
  end

  // Bus and handshake outputs. HTRANS is the only output that can change
  // during a wait state, and only when an error cancels the address phase.
  always_comb begin
    bus.HTRANS    = TRANS_IDLE;
    if (aph_valid & ~aph_illegal & ~hold) begin
      bus.HTRANS  = TRANS_NONSEQ;
    end
    bus.HADDR     = aph_addr;
    bus.HWRITE    = aph_write;
    bus.HSIZE     = {1'b0, aph_size};
    bus.HBURST    = 3'b000;
    bus.HPROT     = HPROT_VAL;
    bus.HMASTLOCK = 1'b0;
    bus.HWDATA    = dph_wdata;
    bus.cmd_ready = cmd_ready_int;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_err   = rsp_err_q;
    bus.rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: tb/tb_ahb_lite_single_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_single_master
// Directed self-checking bench for ahb_lite_single_master. The bench plays
// both the command engine and the AHB slave, cycle by cycle. Inputs change
// 1 ns after the rising edge and outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_ahb_lite_single_master;

  logic HCLK;
  logic HRESET;
  int   n_cmp;
  int   n_fail;

  ahb_lite_single_master_if #(.ADDR_WIDTH(32)) bus_if ();

  ahb_lite_single_master #(
    .ADDR_WIDTH (32),
    .HPROT_VAL  (4'b0011)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus_if)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // park the engine and make the slave ready/OKAY
  task automatic drive_idle();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_size  = 2'd0;
    bus_if.cmd_addr  = 32'h0;
    bus_if.cmd_wdata = 32'h0;
    bus_if.HREADY    = 1'b1;
    bus_if.HRESP     = 1'b0;
    bus_if.HRDATA    = 32'h0;
  endtask

  task automatic drive_cmd(input logic wr, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd);
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_size  = sz;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wd;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    drive_idle();
    step();
    step();
    #1;
    n_cmp++; if (bus_if.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", bus_if.cmd_ready); end
    n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_htrans: got %b want 00", bus_if.HTRANS); end
    n_cmp++; if (bus_if.HADDR !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_haddr: got %h want 0", bus_if.HADDR); end
    n_cmp++; if (bus_if.HWRITE !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_hwrite: got %b want 0", bus_if.HWRITE); end
    n_cmp++; if (bus_if.HSIZE !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_hsize: got %h want 0", bus_if.HSIZE); end
    n_cmp++; if (bus_if.HWDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_hwdata: got %h want 0", bus_if.HWDATA); end
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rsp_err: got %b want 0", bus_if.rsp_err); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_rsp_rdata: got %h want 0", bus_if.rsp_rdata); end
    n_cmp++; if (bus_if.HBURST !== 3'b000) begin n_fail++; $display("[TB] FAIL rst_hburst: got %b want 000", bus_if.HBURST); end
    n_cmp++; if (bus_if.HPROT !== 4'b0011) begin n_fail++; $display("[TB] FAIL rst_hprot: got %b want 0011", bus_if.HPROT); end
    n_cmp++; if (bus_if.HMASTLOCK !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_hmastlock: got %b want 0", bus_if.HMASTLOCK); end
    HRESET = 1'b0;
    #1;
    n_cmp++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b want 1", bus_if.cmd_ready); end
    step();
  endtask

  task automatic test_single_write();
    // cycle 0: accept
    drive_cmd(1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_cmd_ready: got %b want 1", bus_if.cmd_ready); end
    step();
    // cycle 1: address phase
    drive_idle();
    #1;
    n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL wr_htrans: got %b want 10", bus_if.HTRANS); end
    n_cmp++; if (bus_if.HADDR !== 32'h2000_0010) begin n_fail++; $display("[TB] FAIL wr_haddr: got %h want 20000010", bus_if.HADDR); end
    n_cmp++; if (bus_if.HWRITE !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_hwrite: got %b want 1", bus_if.HWRITE); end
    n_cmp++; if (bus_if.HSIZE !== 3'd2) begin n_fail++; $display("[TB] FAIL wr_hsize: got %h want 2", bus_if.HSIZE); end
    step();
    // cycle 2: data phase
    #1;
    n_cmp++; if (bus_if.HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL wr_hwdata: got %h want deadbeef", bus_if.HWDATA); end
    n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL wr_htrans_idle: got %b want 00", bus_if.HTRANS); end
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rsp_early: got %b want 0", bus_if.rsp_valid); end
    step();
    // cycle 3: response
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rsp_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rsp_err: got %b want 0", bus_if.rsp_err); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL wr_rsp_rdata: got %h want 0", bus_if.rsp_rdata); end
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_rsp_once: got %b want 0", bus_if.rsp_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    drive_cmd(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    step();
    drive_cmd(1'b0, 2'd2, 32'h0000_0104, 32'h0);
    #1;
    n_cmp++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_cmd_ready: got %b want 1", bus_if.cmd_ready); end
    n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_htrans_a: got %b want 10", bus_if.HTRANS); end
    n_cmp++; if (bus_if.HADDR !== 32'h100) begin n_fail++; $display("[TB] FAIL b2b_haddr_a: got %h want 100", bus_if.HADDR); end
    step();
    drive_idle();
    bus_if.HRDATA = 32'h11;
    #1;
    n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_htrans_b: got %b want 10", bus_if.HTRANS); end
    n_cmp++; if (bus_if.HADDR !== 32'h104) begin n_fail++; $display("[TB] FAIL b2b_haddr_b: got %h want 104", bus_if.HADDR); end
    step();
    bus_if.HRDATA = 32'h22;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp_a_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h11) begin n_fail++; $display("[TB] FAIL b2b_rsp_a_rdata: got %h want 11", bus_if.rsp_rdata); end
    step();
    bus_if.HRDATA = 32'h0;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_rsp_b_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h22) begin n_fail++; $display("[TB] FAIL b2b_rsp_b_rdata: got %h want 22", bus_if.rsp_rdata); end
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_rsp_end: got %b want 0", bus_if.rsp_valid); end
    step();
  endtask

  task automatic test_wait_states();
    drive_cmd(1'b0, 2'd2, 32'h0000_0200, 32'h0);
    step();
    drive_cmd(1'b0, 2'd2, 32'h0000_0204, 32'h0);
    #1;
    n_cmp++; if (bus_if.HADDR !== 32'h200) begin n_fail++; $display("[TB] FAIL ws_haddr_a: got %h want 200", bus_if.HADDR); end
    step();
    // three wait states on the data phase of 0x200, a third command offered
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b1, 2'd2, 32'h0000_0208, 32'h1234_5678);
      bus_if.HREADY = 1'b0;
      #1;
      n_cmp++; if (bus_if.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_cmd_ready[%0d]: got %b want 0", i, bus_if.cmd_ready); end
      n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL ws_htrans[%0d]: got %b want 10", i, bus_if.HTRANS); end
      n_cmp++; if (bus_if.HADDR !== 32'h204) begin n_fail++; $display("[TB] FAIL ws_haddr[%0d]: got %h want 204", i, bus_if.HADDR); end
      n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_rsp_early[%0d]: got %b want 0", i, bus_if.rsp_valid); end
      step();
    end
    drive_idle();
    bus_if.HRDATA = 32'h33;
    #1;
    n_cmp++; if (bus_if.HADDR !== 32'h204) begin n_fail++; $display("[TB] FAIL ws_haddr_end: got %h want 204", bus_if.HADDR); end
    step();
    bus_if.HRDATA = 32'h44;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ws_rsp_a_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h33) begin n_fail++; $display("[TB] FAIL ws_rsp_a_rdata: got %h want 33", bus_if.rsp_rdata); end
    step();
    bus_if.HRDATA = 32'h0;
    #1;
    n_cmp++; if (bus_if.rsp_rdata !== 32'h44) begin n_fail++; $display("[TB] FAIL ws_rsp_b_rdata: got %h want 44", bus_if.rsp_rdata); end
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ws_rsp_end: got %b want 0", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL ws_no_third: got %b want 00", bus_if.HTRANS); end
    step();
  endtask

  task automatic test_error();
    logic [1:0] exp_trans_err;
    logic       exp_rsp_c5;
    logic       exp_rsp_c6;
`ifdef AHB_MST_ERR_CANCEL_EN
    exp_trans_err = 2'b00;
    exp_rsp_c5    = 1'b0;
    exp_rsp_c6    = 1'b1;
`else
    exp_trans_err = 2'b10;
    exp_rsp_c5    = 1'b1;
    exp_rsp_c6    = 1'b0;
`endif
    drive_cmd(1'b0, 2'd2, 32'hF000_0000, 32'h0);
    step();
    drive_cmd(1'b0, 2'd2, 32'h0000_0300, 32'h0);
    #1;
    n_cmp++; if (bus_if.HADDR !== 32'hF000_0000) begin n_fail++; $display("[TB] FAIL err_haddr_a: got %h want f0000000", bus_if.HADDR); end
    step();
    // first error cycle
    drive_idle();
    bus_if.HREADY = 1'b0;
    bus_if.HRESP  = 1'b1;
    #1;
    n_cmp++; if (bus_if.HTRANS !== exp_trans_err) begin n_fail++; $display("[TB] FAIL err_htrans_1st: got %b want %b", bus_if.HTRANS, exp_trans_err); end
    n_cmp++; if (bus_if.cmd_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cmd_ready: got %b want 0", bus_if.cmd_ready); end
    step();
    // second error cycle
    bus_if.HREADY = 1'b1;
    bus_if.HRDATA = 32'hBAD0_BAD0;
    #1;
    n_cmp++; if (bus_if.HTRANS !== exp_trans_err) begin n_fail++; $display("[TB] FAIL err_htrans_2nd: got %b want %b", bus_if.HTRANS, exp_trans_err); end
    step();
    bus_if.HRESP  = 1'b0;
    bus_if.HRDATA = 32'h55;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL err_rsp_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_rsp_err: got %b want 1", bus_if.rsp_err); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL err_rsp_rdata: got %h want 0", bus_if.rsp_rdata); end
`ifdef AHB_MST_ERR_CANCEL_EN
    n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL err_reissue: got %b want 10", bus_if.HTRANS); end
    n_cmp++; if (bus_if.HADDR !== 32'h300) begin n_fail++; $display("[TB] FAIL err_reissue_addr: got %h want 300", bus_if.HADDR); end
`endif
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== exp_rsp_c5) begin n_fail++; $display("[TB] FAIL err_rsp_b_c5: got %b want %b", bus_if.rsp_valid, exp_rsp_c5); end
    if (exp_rsp_c5) begin
      n_cmp++; if (bus_if.rsp_rdata !== 32'h55 || bus_if.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_rsp_b_data: got %h/%b want 55/0", bus_if.rsp_rdata, bus_if.rsp_err); end
    end
    step();
    bus_if.HRDATA = 32'h0;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== exp_rsp_c6) begin n_fail++; $display("[TB] FAIL err_rsp_b_c6: got %b want %b", bus_if.rsp_valid, exp_rsp_c6); end
    if (exp_rsp_c6) begin
      n_cmp++; if (bus_if.rsp_rdata !== 32'h55 || bus_if.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_rsp_b_data: got %h/%b want 55/0", bus_if.rsp_rdata, bus_if.rsp_err); end
    end
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL err_rsp_end: got %b want 0", bus_if.rsp_valid); end
    step();
  endtask

  task automatic test_illegal();
    // misaligned word access on its own
    drive_cmd(1'b1, 2'd2, 32'h0000_0102, 32'hCAFE_F00D);
    #1;
    n_cmp++; if (bus_if.cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_cmd_ready: got %b want 1", bus_if.cmd_ready); end
    step();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL ill_htrans[%0d]: got %b want 00", i, bus_if.HTRANS); end
      n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_rsp_early[%0d]: got %b want 0", i, bus_if.rsp_valid); end
      step();
    end
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_rsp_valid: got %b want 1", bus_if.rsp_valid); end
    n_cmp++; if (bus_if.rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_rsp_err: got %b want 1", bus_if.rsp_err); end
    step();
    // size 3 queued behind a legal read keeps its place
    drive_cmd(1'b0, 2'd2, 32'h0000_0400, 32'h0);
    step();
    drive_cmd(1'b0, 2'd3, 32'h0000_0404, 32'h0);
    #1;
    n_cmp++; if (bus_if.HADDR !== 32'h400) begin n_fail++; $display("[TB] FAIL ill_legal_haddr: got %h want 400", bus_if.HADDR); end
    step();
    drive_idle();
    bus_if.HRDATA = 32'h66;
    #1;
    n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL ill_sz3_htrans: got %b want 00", bus_if.HTRANS); end
    step();
    bus_if.HRDATA = 32'h0;
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_order_first: got %b/%b want 1/0", bus_if.rsp_valid, bus_if.rsp_err); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h66) begin n_fail++; $display("[TB] FAIL ill_order_rdata: got %h want 66", bus_if.rsp_rdata); end
    step();
    #1;
    n_cmp++; if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_order_second: got %b/%b want 1/1", bus_if.rsp_valid, bus_if.rsp_err); end
    n_cmp++; if (bus_if.rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL ill_sz3_rdata: got %h want 0", bus_if.rsp_rdata); end
    step();
  endtask

  task automatic test_reset_mid_transfer();
    drive_cmd(1'b0, 2'd2, 32'h0000_0500, 32'h0);
    step();
    drive_idle();
    #1;
    n_cmp++; if (bus_if.HTRANS !== 2'b10) begin n_fail++; $display("[TB] FAIL mrst_htrans_pre: got %b want 10", bus_if.HTRANS); end
    step();
    // data phase waiting when reset hits
    bus_if.HREADY = 1'b0;
    HRESET        = 1'b1;
    step();
    bus_if.HREADY = 1'b1;
    bus_if.HRDATA = 32'h77;
    #1;
    n_cmp++; if (bus_if.HTRANS !== 2'b00) begin n_fail++; $display("[TB] FAIL mrst_htrans: got %b want 00", bus_if.HTRANS); end
    n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_rsp_valid: got %b want 0", bus_if.rsp_valid); end
    HRESET = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus_if.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mrst_no_rsp[%0d]: got %b want 0", i, bus_if.rsp_valid); end
      step();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    HRESET = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_illegal();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_single_master.md
Name: ahb_lite_single_master

Overview:
AHB-Lite initiator that turns a simple command/response interface into single (HBURST=SINGLE) AHB-Lite transfers.
- Address and data phases are pipelined, so back-to-back commands reach the bus with no idle cycle.
- It handles slave wait states and the two-cycle ERROR response, including the error responses returned by the default slave on unmapped regions.
- It sits between an internal engine (DMA channel or test driver) and the bus matrix or decoder.

Parameters:
ADDR_WIDTH, 32, width of HADDR and cmd_addr.
HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, non-bufferable, privileged, data).

Ports:
HCLK  input  1  clock
HRESET  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_size  input  2  HSIZE encoding: 0 = byte, 1 = half, 2 = word; 3 is illegal
cmd_addr  input  ADDR_WIDTH  byte address
cmd_wdata  input  32  write data, lane-positioned by the sender
rsp_valid  output  1  one-cycle pulse, one per accepted command, in order
rsp_err  output  1  qualifies rsp_valid: ERROR response or illegal command
rsp_rdata  output  32  read data (zero for writes and errors)
HADDR  output  ADDR_WIDTH  address
HTRANS  output  2  IDLE (00) or NONSEQ (10) only
HWRITE  output  1  direction
HSIZE  output  3  {1'b0, size}
HBURST  output  3  constant 000
HPROT  output  4  HPROT_VAL
HMASTLOCK  output  1  constant 0
HWDATA  output  32  write data, driven during the data phase
HRDATA  input  32  read data
HREADY  input  1  bus ready
HRESP  input  1  error response

Behaviour:
Reset (synchronous, HRESET=1 at a posedge):
- HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
- All phase registers invalid.
- A reset in mid-transfer abandons the outstanding phases and produces no response.

Address-phase register (aph):
- Holds addr, write, size and wdata, plus a valid bit.
- HTRANS=NONSEQ when aph valid and not held, otherwise IDLE.
- The other bus outputs come from aph; they hold their last value when aph is idle.

Data-phase register (dph):
- Holds write, wdata and valid.
- HWDATA = dph.wdata.

cmd_ready:
- cmd_ready = ~HRESET & ~hold & (~aph.valid | HREADY).
- Combinational on HREADY.

Accepting a command:
- Load it into aph at the posedge, so NONSEQ appears the cycle after acceptance.

Illegal commands:
- Illegal when cmd_size=3, or when the address is misaligned (half with addr[0]=1; word with addr[1:0]≠0).
- Accepted, but never put on the bus.
- Queued in order behind any outstanding transfers and answered with rsp_valid=1, rsp_err=1, no bus activity.

Phase transfer:
- At a posedge with HREADY=1: aph moves to dph, and a newly accepted command, if any, loads into aph.
- A transfer whose data phase ends (dph.valid & HREADY) produces on the next cycle: rsp_valid=1, rsp_err=HRESP, rsp_rdata = (read & ~HRESP) ? HRDATA : 0.

Error sequencing:
- First error cycle (HRESP=1, HREADY=0): keep waiting.
- Second error cycle (HRESP=1, HREADY=1): completes the transfer with rsp_err=1.

Wait states:
- While HREADY=0, all bus outputs stay stable.
- No command is accepted while aph is valid.

Latency:
- Single read with zero wait states: accept at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, rsp_valid at cycle 3.
- Peak throughput is one response per cycle.

rsp_valid has no backpressure; the consumer must take it.

Optional Feature:
AHB_MST_ERR_CANCEL_EN

Defined:
- In the first error cycle, if aph is valid, set hold=1 and drive HTRANS=IDLE for that cycle.
- The cancelled command stays in aph.
- hold clears after the second error cycle, and the command is reissued as NONSEQ the following cycle.
- No command is lost or duplicated; ordering is preserved.

Undefined:
- hold is tied to 0.
- The pipelined address phase continues unchanged through the error response.

Test Plan:
1. Write word 0xDEADBEEF to 0x2000_0010, HREADY always 1:
   - HTRANS=NONSEQ, HWRITE=1, HSIZE=2 at cycle 1.
   - HWDATA=0xDEADBEEF at cycle 2.
   - rsp_valid=1, rsp_err=0 at cycle 3.
2. Back-to-back reads of 0x100 and 0x104, returning 0x11 and 0x22:
   - consecutive NONSEQ cycles.
   - two responses on consecutive cycles with rsp_rdata 0x11 then 0x22.
3. Read with 3 wait states (HREADY=0 ×3):
   - HADDR and HTRANS stable throughout.
   - cmd_ready=0 for a second command.
   - rsp_valid exactly once, with the correct data.
4. Read of an unmapped address, slave returns ERROR (HRESP=1 with HREADY 0 then 1):
   - rsp_err=1, rsp_rdata=0.
   - With the macro defined, a pipelined next command shows HTRANS=IDLE during the first error cycle, then reissues and completes with rsp_err=0.
5. cmd_size=2 with addr 0x102:
   - no NONSEQ is issued.
   - response is rsp_err=1.
6. HRESET asserted while a data phase is waiting:
   - the next cycle shows HTRANS=IDLE and rsp_valid=0.
   - no response is ever produced for the abandoned command.
